bus_rr_arbiter: RTL

//  Round-robin arbiter sharing one single-outstanding resource (data SRAM / bus port) among N_REQ requesters (IF, MEM, ...).

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 55 +++++
 rtl/bus_rr_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so the search starts after last_ptr,
// find the first set bit, then map the offset back to a requester index.
module rr_pick import arb_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] offset;
    int unsigned      src;
    int unsigned      sum;

    // Explicit wrap keeps non-power-of-2 N_REQ from reaching unused index codes.
    always_comb begin
        if (32'(last_ptr) >= N_REQ - 1) begin
            start = '0;
        end else begin
            start = last_ptr + IDX_W'(1);
        end
    end

    always_comb begin
        rot = '0;
        src = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            src = i + 32'(start);
            if (src >= N_REQ) src = src - N_REQ;
            rot[i] = req[IDX_W'(src)];
        end
    end

    always_comb begin
        any_req = 1'b0;
        offset  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !any_req) begin
                any_req = 1'b1;
                offset  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sum = 32'(offset) + 32'(start);
        if (sum >= N_REQ) sum = sum - N_REQ;
        win_idx = IDX_W'(sum);
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a single-outstanding shared resource; grant is held until bus_done.
// Optional watchdog forced release is enabled by defining ARB_TIMEOUT_EN.
module bus_rr_arbiter import arb_pkg::*; #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned IDX_W       = clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req,
    input  logic             bus_done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout_err
);

    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 16 || IDX_W != clog2(N_REQ) || TIMEOUT_CYC < 1 ||
        TIMEOUT_CYC >= (32'd1 << CNT_W)) begin : g_bad_cfg
        $error("bus_rr_arbiter: inconsistent parameters");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             rel_bus;
    logic             grant_new;
    logic             expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .win_idx  (win_idx),
        .any_req  (any_req)
    );

    // A release re-picks in the same cycle; last_ptr_q already names the owner,
    // so the released requester naturally drops to lowest priority.
    assign rel_bus   = (state_q == ARB_BUSY) && (bus_done || expire);
    assign grant_new = any_req && ((state_q == ARB_IDLE) || rel_bus);

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        if (grant_new) begin
            state_d        = ARB_BUSY;
            last_ptr_d     = win_idx;
            idx_d          = win_idx;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
        end else if (rel_bus) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ARB_IDLE;
            last_ptr_q <= PTR_RESET;
            idx_q      <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q;

    // Completion wins over expiry when both land in the same cycle.
    assign expire = (state_q == ARB_BUSY) && !bus_done &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_new) begin
            cnt_d = '0;
        end else if ((state_q == ARB_BUSY) && !bus_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= expire;
        end
    end

    assign timeout_err = terr_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == ARB_BUSY);

endmodule
